// File: rtl/alu_issue_pkg.sv
// Shared opcodes, ALU encodings and the issued-op record for the ALU issue stage.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [2:0] F3_ADD = 3'b000;

  typedef struct packed {
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic [31:0] store_data;
    logic [31:0] pc;
    logic        illegal;
  } issue_op_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode: maps every supported opcode onto ALU add/sub style operands.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output issue_op_t   op_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign imm_i  = sext12(instr_i[31:20]);
  assign imm_s  = sext12({instr_i[31:25], instr_i[11:7]});
  assign imm_u  = {instr_i[31:12], 12'b0};

  always_comb begin
    op_o            = '0;
    op_o.funct7     = F7_ADD;
    op_o.funct3     = F3_ADD;
    op_o.rd         = instr_i[11:7];
    op_o.store_data = rs2_i;
    op_o.pc         = pc_i;
    case (opcode)
      OPC_OP: begin
        op_o.funct7    = instr_i[31:25];
        op_o.funct3    = f3;
        op_o.a         = rs1_i;
        op_o.b         = rs2_i;
        op_o.reg_write = 1'b1;
      end
      OPC_OPIMM: begin
        // Only SRLI/SRAI carry funct7; ADDI with imm[10]=1 must not become a subtract.
        op_o.funct7    = (f3 == 3'b101) ? instr_i[31:25] : F7_ADD;
        op_o.funct3    = f3;
        op_o.a         = rs1_i;
        op_o.b         = imm_i;
        op_o.reg_write = 1'b1;
      end
      OPC_LUI: begin
        op_o.b         = imm_u;
        op_o.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        op_o.a         = pc_i;
        op_o.b         = imm_u;
        op_o.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        op_o.a         = pc_i;
        op_o.b         = 32'd4;
        op_o.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        op_o.funct7    = F7_SUB;
        op_o.a         = rs1_i;
        op_o.b         = rs2_i;
        op_o.is_branch = 1'b1;
        op_o.br_funct3 = f3;
      end
      OPC_LOAD: begin
        op_o.a         = rs1_i;
        op_o.b         = imm_i;
        op_o.reg_write = 1'b1;
      end
      OPC_STORE: begin
        op_o.a = rs1_i;
        op_o.b = imm_s;
      end
      default: op_o.illegal = 1'b1;
    endcase
    if (instr_i[11:7] == 5'd0) op_o.reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register driving the ALU interface with valid/ready handshake and flush.
// Define ALU_ISSUE_SKID_EN to add a one-entry skid buffer with a registered in_ready.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_is_branch,
  output logic [2:0]      out_br_funct3,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  issue_op_t dec_op;
  issue_op_t out_q, out_d;
  logic      out_valid_q, out_valid_d;
  logic      accept;

  alu_issue_decode u_decode (
    .instr_i (instr),
    .pc_i    (pc),
    .rs1_i   (rs1_data),
    .rs2_i   (rs2_data),
    .op_o    (dec_op)
  );

`ifdef ALU_ISSUE_SKID_EN
  issue_op_t skid_q, skid_d;
  logic      skid_full_q, skid_full_d;

  assign in_ready = !skid_full_q;
`else
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
`ifdef ALU_ISSUE_SKID_EN
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
`endif
    if (rst) begin
      out_d       = '0;
      out_d.pc    = RESET_PC_TAG;
      out_valid_d = 1'b0;
`ifdef ALU_ISSUE_SKID_EN
      skid_d      = '0;
      skid_full_d = 1'b0;
`endif
    end else if (flush) begin
      out_valid_d = 1'b0;
`ifdef ALU_ISSUE_SKID_EN
      skid_full_d = 1'b0;
`endif
    end else begin
`ifdef ALU_ISSUE_SKID_EN
      if (!out_valid_q || out_ready) begin
        // Skid entry is older than anything arriving now, so it drains first.
        if (skid_full_q) begin
          out_d       = skid_q;
          out_valid_d = 1'b1;
          skid_full_d = 1'b0;
        end else if (accept) begin
          out_d       = dec_op;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d      = dec_op;
        skid_full_d = 1'b1;
      end
`else
      if (accept) begin
        out_d       = dec_op;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    out_q       <= out_d;
    out_valid_q <= out_valid_d;
`ifdef ALU_ISSUE_SKID_EN
    skid_q      <= skid_d;
    skid_full_q <= skid_full_d;
`endif
  end

  assign out_valid      = out_valid_q;
  assign out_funct7     = out_q.funct7;
  assign out_funct3     = out_q.funct3;
  assign out_a          = out_q.a;
  assign out_b          = out_q.b;
  assign out_rd         = out_q.rd;
  assign out_reg_write  = out_q.reg_write;
  assign out_is_branch  = out_q.is_branch;
  assign out_br_funct3  = out_q.br_funct3;
  assign out_store_data = out_q.store_data;
  assign out_pc         = out_q.pc;
  assign out_illegal    = out_q.illegal;

endmodule
